cmul_sequencer: RTL and testbench
=================================

# cmul_sequencer

Sequences one shared registered signed multiplier through the four real products of a complex multiply: (ar + j·ai)·(br + j·bi). The butterfly/twiddle stage of the 32-point FFT presents operands on a valid/ready input. The block drives the multiplier's operand ports, accumulates the products in full precision, and rescales to Q1.(W-1) with saturation. The result is held on a valid/ready output until consumed.

## Interface
- DATA_WIDTH, default 32: width W of every real/imag input and output component (signed Q1.(W-1)).
- clk  input  1  clock; all state updates on rising edge.
- aclr  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept; high only in IDLE.
- in_ar, in_ai, in_br, in_bi  input  W each  signed operands a and b (b is the twiddle).
- mul_a, mul_b  output  W each  operands to the shared multiplier.
- mul_p  input  2W  multiplier product, registered inside the multiplier: reflects mul_a·mul_b of the previous cycle.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_re, out_im  output  W each  signed result components.
- out_sat  output  1  either component saturated for the current result.
- busy  output  1  high in every state except IDLE.

## Operation
- On reset, all outputs are 0 (in_ready is 1 once state is IDLE) and operand/accumulator registers are cleared. Reset mid-operation aborts the operation; the partial result is discarded.
- Operands are latched on the in_valid & in_ready edge. Inputs are ignored at all other times.
- FSM states: IDLE, RR, II, RI, IR, WB, OUT. Transitions:
  - IDLE→RR on accept.
  - RR→II→RI→IR→WB→OUT unconditionally.
  - OUT→IDLE on out_ready.
- Multiplier operands per state:
  - RR: ar, br.
  - II: ai, bi.
  - RI: ar, bi.
  - IR: ai, br.
  - All other states: 0, 0.
- Accumulation, with accumulators acc_re and acc_im both 2W+1 bits, sign-extended:
  - II: acc_re ← p(rr).
  - RI: acc_re ← acc_re − p(ii).
  - IR: acc_im ← p(ri).
  - WB: acc_im ← acc_im + p(ir).
- At the end of WB, each accumulator is rescaled and registered into out_re/out_im, out_sat is set, and out_valid is set.
- Rescale: s = acc >>> (W−1), an arithmetic shift, i.e. floor.
  - If s > 2^(W−1)−1, the output is 2^(W−1)−1.
  - If s < −2^(W−1), the output is −2^(W−1).
  - Either clamp sets out_sat.
- out_re, out_im and out_sat hold stable while out_valid=1 and out_ready=0. They keep their last value after the handshake; out_valid drops.
- Back-to-back operation: a new operand set is accepted only after returning to IDLE, so an in_valid held through OUT is accepted on the cycle after the out handshake.

## Timing
- Acceptance edge E0. out_valid rises after E5, giving 5 cycles of latency.
- Minimum issue interval is 7 cycles (6 busy cycles plus 1 IDLE), achieved with out_ready tied high.
- in_ready and busy are decoded from the state register with no combinational path from in_valid or out_ready.
- mul_a and mul_b are decoded from the state register and latched operands. They are stable for the whole cycle.

## Configuration
- CMUL_ROUND_EN defined: 2^(W−2) is added to each accumulator before the shift, giving round-half-up. Saturation is applied after rounding.
- CMUL_ROUND_EN undefined: plain floor truncation, with no adder in the rescale path.
- FSM, latency and handshakes are identical in both builds.

## Test plan
All scenarios use W=8.
- Reset: assert aclr=0 mid-operation (in state RI) → out_valid=0, out_re=out_im=0, busy=0, in_ready=1 immediately. A new set is accepted normally after release.
- Nominal: a=(64,0), b=(64,64) → out_re=32, out_im=32, out_sat=0. out_valid rises exactly 5 cycles after the accept edge. mul_a/mul_b sequence is (64,64), (0,64), (64,64), (0,64).
- Saturation: a=(−128,−128), b=(−128,127) → out_re=127, out_im=1, out_sat=1.
- Rounding:
  - a=(1,0), b=(64,0): without the macro out_re=0; with CMUL_ROUND_EN out_re=1.
  - a=(−1,0), b=(64,0): without the macro out_re=−1; with CMUL_ROUND_EN out_re=0.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and a second operand set waiting → outputs stay stable and in_ready=0 throughout. The second set is accepted the cycle after out_ready=1.
- Throughput: out_ready tied 1 and in_valid tied 1 with 4 random sets → results match a golden model, with one result every 7 cycles.

Source files
------------

// File: rtl/cmul_if.sv
// cmul_if: operand, multiplier and result handshake bundle for cmul_sequencer
interface cmul_if #(parameter int DATA_WIDTH = 32);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_ar, in_ai, in_br, in_bi;
  logic [DATA_WIDTH-1:0]     mul_a, mul_b;
  logic [2*DATA_WIDTH-1:0]   mul_p;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_re, out_im;
  logic                      out_sat;
  logic                      busy;
  modport master (
    output in_valid, in_ar, in_ai, in_br, in_bi, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_re, out_im, out_sat, busy
  );
  modport slave (
    input  in_valid, in_ar, in_ai, in_br, in_bi, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_re, out_im, out_sat, busy
  );
endinterface

// File: rtl/cmul_sequencer.sv
// cmul_sequencer: complex multiply over one shared registered multiplier, Q1.(W-1) out with saturation
// Define CMUL_ROUND_EN for round-half-up rescaling instead of floor truncation.
module cmul_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input logic   clk,
  input logic   aclr,
  cmul_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int AW = 2 * W + 1;
  localparam logic signed [AW-1:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, RR, II, RI, IR, WB, OUT} state_t;
  state_t state, state_d;
  logic [W-1:0] ar, ai, br, bi;
  logic [W-1:0] re_o, im_o;
  logic signed [AW-1:0] acc_re, acc_im, acc_im_nxt, p_ext, re_s, im_s;
  logic re_sat, im_sat;
  assign p_ext          = {bus.mul_p[2*W-1], bus.mul_p};
  assign acc_im_nxt     = acc_im + p_ext;
  assign bus.in_ready   = state == IDLE;
  assign bus.busy       = state != IDLE;
  assign bus.out_valid  = state == OUT;
`ifdef CMUL_ROUND_EN
  localparam logic signed [AW-1:0] RND = {{(W+2){1'b0}}, 1'b1, {(W-2){1'b0}}};
  assign re_s = (acc_re + RND) >>> (W - 1);
  assign im_s = (acc_im_nxt + RND) >>> (W - 1);
`else
  assign re_s = acc_re >>> (W - 1);
  assign im_s = acc_im_nxt >>> (W - 1);
`endif
  always_comb begin
    state_d   = state == IDLE ? (bus.in_valid ? RR : IDLE)
              : state == OUT  ? (bus.out_ready ? IDLE : OUT)
              : state_t'(state + 3'd1);
    bus.mul_a = (state == RR || state == RI) ? ar : (state == II || state == IR) ? ai : '0;
    bus.mul_b = (state == RR || state == IR) ? br : (state == II || state == RI) ? bi : '0;
    re_sat    = re_s > MAXV || re_s < MINV;
    im_sat    = im_s > MAXV || im_s < MINV;
    re_o      = re_s > MAXV ? MAXV[W-1:0] : re_s < MINV ? MINV[W-1:0] : re_s[W-1:0];
    im_o      = im_s > MAXV ? MAXV[W-1:0] : im_s < MINV ? MINV[W-1:0] : im_s[W-1:0];
  end
  // each product arrives one cycle after its operands were issued
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state       <= IDLE;
      {ar, ai, br, bi} <= '0;
      acc_re      <= '0;
      acc_im      <= '0;
      bus.out_re  <= '0;
      bus.out_im  <= '0;
      bus.out_sat <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && bus.in_valid) {ar, ai, br, bi} <= {bus.in_ar, bus.in_ai, bus.in_br, bus.in_bi};
      if (state == II) acc_re <= p_ext;
      if (state == RI) acc_re <= acc_re - p_ext;
      if (state == IR) acc_im <= p_ext;
      if (state == WB) begin
        acc_im      <= acc_im_nxt;
        bus.out_re  <= re_o;
        bus.out_im  <= im_o;
        bus.out_sat <= re_sat | im_sat;
      end
    end
  end
endmodule

// File: tb/tb_cmul_sequencer.sv
// tb_cmul_sequencer: scoreboard bench for cmul_sequencer at W=8 with a registered multiplier model
module tb_cmul_sequencer;
  logic clk = 0;
  logic aclr = 0;
  int total = 0, bad = 0, cyc = 0;
  logic [16:0] exp_q[$];
  cmul_if #(.DATA_WIDTH(8)) bus ();
  cmul_sequencer #(.DATA_WIDTH(8)) dut (.clk(clk), .aclr(aclr), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  logic signed [15:0] ea, eb;
  assign ea = {{8{bus.mul_a[7]}}, bus.mul_a};
  assign eb = {{8{bus.mul_b[7]}}, bus.mul_b};
  always @(posedge clk) bus.mul_p <= ea * eb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] cref(input int ar, input int ai, input int br, input int bi);
    int re, im;
    logic [7:0] r8, i8;
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
`ifdef CMUL_ROUND_EN
    re += 64;
    im += 64;
`endif
    re = re >>> 7;
    im = im >>> 7;
    r8 = re > 127 ? 8'd127 : re < -128 ? 8'h80 : re[7:0];
    i8 = im > 127 ? 8'd127 : im < -128 ? 8'h80 : im[7:0];
    return {(re > 127 || re < -128 || im > 127 || im < -128), r8, i8};
  endfunction

  always @(negedge clk) begin
    if (aclr && bus.in_valid && bus.in_ready)
      exp_q.push_back(cref($signed(bus.in_ar), $signed(bus.in_ai), $signed(bus.in_br), $signed(bus.in_bi)));
    if (aclr && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("unexpected_result", 1, 0);
      else check("result", {bus.out_sat, bus.out_re, bus.out_im}, exp_q.pop_front());
    end
  end

  task automatic send(input logic signed [7:0] ar, ai, br, bi, output int t);
    logic ok;
    int n = 0;
    {bus.in_ar, bus.in_ai, bus.in_br, bus.in_bi} = {ar, ai, br, bi};
    bus.in_valid = 1;
    do begin
      ok = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) check("accept_timeout", 0, 1);
    t = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int t, tp;
    logic [7:0] r[4];
    {bus.in_valid, bus.in_ar, bus.in_ai, bus.in_br, bus.in_bi} = '0;
    bus.out_ready = 1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out", {bus.out_sat, bus.out_re, bus.out_im}, 0);
    repeat (2) @(posedge clk);
    #1 aclr = 1;
    @(posedge clk); #1;
    send(64, 0, 64, 64, t);
    bus.in_valid = 0;
    check("nom_mul_rr", {bus.mul_a, bus.mul_b}, 16'h4040);
    @(posedge clk); #1;
    check("nom_mul_ii", {bus.mul_a, bus.mul_b}, 16'h0040);
    @(posedge clk); #1;
    check("nom_mul_ri", {bus.mul_a, bus.mul_b}, 16'h4040);
    @(posedge clk); #1;
    check("nom_mul_ir", {bus.mul_a, bus.mul_b}, 16'h0040);
    @(posedge clk); #1;
    check("nom_valid_e4", bus.out_valid, 0);
    check("nom_mul_wb", {bus.mul_a, bus.mul_b}, 16'h0000);
    @(posedge clk); #1;
    check("nom_valid_e5", bus.out_valid, 1);
    drain();
    check("nom_out", {bus.out_sat, bus.out_re, bus.out_im}, {1'b0, 8'd32, 8'd32});
    send(1, 2, 3, 4, t);
    bus.in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    check("mid_busy", bus.busy, 1);
    aclr = 0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out", {bus.out_re, bus.out_im}, 0);
    exp_q.delete();
    #2 aclr = 1;
    @(posedge clk); #1;
    send(-128, -128, -128, 127, t);
    bus.in_valid = 0;
    check("post_rst_busy", bus.busy, 1);
    drain();
    check("sat_out", {bus.out_sat, bus.out_re, bus.out_im}, {1'b1, 8'd127, 8'd1});
    send(1, 0, 64, 0, t);
    bus.in_valid = 0;
    drain();
`ifdef CMUL_ROUND_EN
    check("rnd_pos", bus.out_re, 8'd1);
`else
    check("rnd_pos", bus.out_re, 8'd0);
`endif
    send(-1, 0, 64, 0, t);
    bus.in_valid = 0;
    drain();
`ifdef CMUL_ROUND_EN
    check("rnd_neg", bus.out_re, 8'd0);
`else
    check("rnd_neg", bus.out_re, 8'hff);
`endif
    bus.out_ready = 0;
    send(100, -50, 90, 30, t);
    {bus.in_ar, bus.in_ai, bus.in_br, bus.in_bi} = {8'd7, 8'd9, 8'd11, 8'd13};
    for (int n = 0; n < 20 && !bus.out_valid; n++) begin @(posedge clk); #1; end
    check("bp_valid", bus.out_valid, 1);
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_hold", {bus.out_valid, bus.in_ready, bus.out_sat, bus.out_re, bus.out_im},
            {1'b1, 1'b0, cref(100, -50, 90, 30)});
    end
    bus.out_ready = 1;
    @(posedge clk); #1;
    check("bp_idle", bus.in_ready, 1);
    @(posedge clk); #1;
    check("bp_second_accept", bus.busy, 1);
    bus.in_valid = 0;
    drain();
    for (int i = 0; i < 4; i++) begin
      foreach (r[k]) r[k] = 8'($urandom);
      send(r[0], r[1], r[2], r[3], t);
      if (i > 0) check("interval", t - tp, 7);
      tp = t;
    end
    bus.in_valid = 0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
